// File: rtl/sar_pkg.sv
// Shared types and constants for the successive-approximation search controller.
package sar_pkg;

  localparam int SAR_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PROBE = 2'd1,
    DONE  = 2'd2
  } sar_state_e;

  // Comparator flags packed as {grt, ls, eq}.
  localparam logic [2:0] FLAG_GRT = 3'b100;
  localparam logic [2:0] FLAG_LS  = 3'b010;
  localparam logic [2:0] FLAG_EQ  = 3'b001;

endpackage

// File: rtl/sar_search_ctrl.sv
// Binary-search initiator: drives comparator B with one probe per clock and
// narrows [lo, hi] from the comparator flags until it hits equality or gives up.
module sar_search_ctrl
  import sar_pkg::*;
#(
  parameter int  WIDTH = SAR_WIDTH,
  parameter int  MAXP  = WIDTH + 1,
  localparam int PW    = $clog2(MAXP + 1)
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  output logic [WIDTH-1:0] Guess,
  input  logic             Grt,
  input  logic             Ls,
  input  logic             Eq,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic             Error,
  output logic [PW-1:0]    Probes
);

  localparam logic [WIDTH:0]   TOP  = {1'b0, {WIDTH{1'b1}}};
  localparam logic [WIDTH-1:0] MAXG = {WIDTH{1'b1}};

  sar_state_e       state_q, state_d;
  logic [WIDTH:0]   lo_q, lo_d, hi_q, hi_d;
  logic [WIDTH-1:0] guess_q, guess_d, result_q, result_d;
  logic             busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic [PW-1:0]    probes_q, probes_d;

  logic [2:0]       flags;
  logic [WIDTH:0]   g_ext, lo_n, hi_n;
  logic             fail;

  assign flags = {Grt, Ls, Eq};
  assign g_ext = {1'b0, guess_q};

  always_comb begin
    state_d  = state_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    guess_d  = guess_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    error_d  = error_q;
    probes_d = probes_q;
    lo_n     = lo_q;
    hi_n     = hi_q;
    fail     = 1'b0;

    case (state_q)
      IDLE: begin
        if (Start) begin
          lo_d     = '0;
          hi_d     = TOP;
          guess_d  = {1'b0, {(WIDTH-1){1'b1}}};
          probes_d = '0;
          error_d  = 1'b0;
          busy_d   = 1'b1;
          state_d  = PROBE;
        end
      end

      PROBE: begin
        probes_d = probes_q + PW'(1);
        case (flags)
          FLAG_EQ:  ;
          FLAG_GRT: if (guess_q == MAXG) fail = 1'b1; else lo_n = g_ext + 1'b1;
          FLAG_LS:  if (guess_q == '0)   fail = 1'b1; else hi_n = g_ext - 1'b1;
          default:  fail = 1'b1;
        endcase
        // Crossed bounds mean the target moved under us mid-search.
        if (lo_n > hi_n) fail = 1'b1;
        if (flags != FLAG_EQ && (int'(probes_q) + 1) >= MAXP) fail = 1'b1;

        if (fail) begin
          error_d  = 1'b1;
          result_d = guess_q;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          state_d  = DONE;
        end else if (flags == FLAG_EQ) begin
          result_d = guess_q;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          state_d  = DONE;
        end else begin
          lo_d    = lo_n;
          hi_d    = hi_n;
          guess_d = WIDTH'((lo_n + hi_n) >> 1);
        end
      end

      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q  <= IDLE;
      lo_q     <= '0;
      hi_q     <= '0;
      guess_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      error_q  <= 1'b0;
      probes_q <= '0;
    end else begin
      state_q  <= state_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      guess_q  <= guess_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      error_q  <= error_d;
      probes_q <= probes_d;
    end
  end

  assign Guess  = guess_q;
  assign Busy   = busy_q;
  assign Done   = done_q;
  assign Result = result_q;
  assign Error  = error_q;
  assign Probes = probes_q;

endmodule

// File: tb/tb_sar_search_ctrl.sv
// Bench for sar_search_ctrl: behavioural comparator on A, vector table,
// hand-written corner sequences and randomized targets against a reference search.
module tb_sar_search_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [3:0] a_val = 4'd0;
  logic [3:0] guess, result;
  logic [2:0] probes;
  logic       grt, ls, eq, busy, done, error;
  bit         force_en = 1'b0;
  logic [2:0] force_val = 3'b000;

  int checks = 0;
  int failures = 0;
  int gq[$];
  int exq[$];

  always #5 clk = ~clk;

  // Comparator behaviour, with an override for injecting illegal flag patterns.
  always_comb begin
    if (force_en) {grt, ls, eq} = force_val;
    else {grt, ls, eq} = {a_val > guess, a_val < guess, a_val == guess};
  end

  sar_search_ctrl dut (
    .Clk(clk), .Rst(rst), .Start(start), .Guess(guess),
    .Grt(grt), .Ls(ls), .Eq(eq), .Busy(busy), .Done(done),
    .Result(result), .Error(error), .Probes(probes)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_seq(input string name, input int exp[$]);
    chk({name, "_len"}, gq.size(), exp.size());
    for (int i = 0; i < exp.size() && i < gq.size(); i++)
      chk($sformatf("%s_g%0d", name, i), gq[i], exp[i]);
  endtask

  // Textbook binary search over the full operand range.
  function automatic void ref_search(input int a, output int res, output int n);
    int lo = 0, hi = 15, g;
    exq.delete();
    n = 0;
    res = -1;
    while (lo <= hi) begin
      g = (lo + hi) / 2;
      n++;
      exq.push_back(g);
      if (g == a) begin res = g; break; end
      else if (a > g) lo = g + 1;
      else hi = g - 1;
    end
  endfunction

  task automatic run(input int a, input bit noise, input int chg_at, input int chg_a,
                     input int rst_at, output int res, output int prb, output int err,
                     output int cyc, output bit timed_out);
    a_val = 4'(a);
    gq.delete();
    res = -1; prb = -1; err = -1; cyc = -1;
    timed_out = 1'b1;
    start = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      if (busy) begin
        gq.push_back(int'(guess));
        if (gq.size() == chg_at) a_val = 4'(chg_a);
        if (gq.size() == rst_at) begin
          rst = 1'b0;
          timed_out = 1'b0;
          cyc = k;
          break;
        end
      end
      if (done) begin
        res = int'(result); prb = int'(probes); err = int'(error);
        cyc = k;
        timed_out = 1'b0;
        break;
      end
    end
    chk("timeout", int'(timed_out), 0);
  endtask

  task automatic after_done();
    @(posedge clk); #1;
    start = 1'b0;
    chk("done_pulse", int'(done), 0);
    chk("busy_idle", int'(busy), 0);
  endtask

  typedef struct {
    int a;
    int res;
    int prb;
    int err;
  } vec_t;

  initial begin
    vec_t tbl[6];
    int res, prb, err, cyc, n, eres;
    bit to;
    int seq0[$], seq15[$], seqmv[$];

    tbl[0] = '{7, 7, 1, 0};
    tbl[1] = '{0, 0, 4, 0};
    tbl[2] = '{15, 15, 5, 0};
    tbl[3] = '{9, 9, 3, 0};
    tbl[4] = '{12, 12, 4, 0};
    tbl[5] = '{8, 8, 4, 0};
    seq0  = '{7, 3, 1, 0};
    seq15 = '{7, 11, 13, 14, 15};
    seqmv = '{7, 11, 13, 12};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_guess", int'(guess), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_error", int'(error), 0);
    chk("rst_probes", int'(probes), 0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("idle_no_start", int'(busy), 0);

    foreach (tbl[i]) begin
      run(tbl[i].a, 1'b0, 0, 0, 0, res, prb, err, cyc, to);
      chk($sformatf("tbl%0d_result", i), res, tbl[i].res);
      chk($sformatf("tbl%0d_probes", i), prb, tbl[i].prb);
      chk($sformatf("tbl%0d_error", i), err, tbl[i].err);
      chk($sformatf("tbl%0d_latency", i), cyc, tbl[i].prb + 1);
      if (tbl[i].a == 0)  chk_seq("seq_a0", seq0);
      if (tbl[i].a == 15) chk_seq("seq_a15", seq15);
      after_done();
    end

    force_en = 1'b1;
    force_val = 3'b000;
    run(7, 1'b0, 0, 0, 0, res, prb, err, cyc, to);
    chk("flags000_error", err, 1);
    chk("flags000_result", res, 7);
    chk("flags000_probes", prb, 1);
    after_done();
    chk("error_held", int'(error), 1);
    force_val = 3'b110;
    run(3, 1'b0, 0, 0, 0, res, prb, err, cyc, to);
    chk("flags110_error", err, 1);
    after_done();
    force_en = 1'b0;

    run(12, 1'b0, 3, 2, 0, res, prb, err, cyc, to);
    chk("moved_error", err, 1);
    chk("moved_result", res, 12);
    chk("moved_probes", prb, 4);
    chk_seq("moved_seq", seqmv);
    after_done();

    run(0, 1'b0, 0, 0, 3, res, prb, err, cyc, to);
    @(posedge clk); #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_guess", int'(guess), 0);
    chk("midrst_probes", int'(probes), 0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_no_done", int'(done), 0);
    run(9, 1'b0, 0, 0, 0, res, prb, err, cyc, to);
    chk("postrst_result", res, 9);
    chk("postrst_error", err, 0);
    after_done();

    for (int t = 0; t < 40; t++) begin
      int a = int'($urandom_range(0, 15));
      ref_search(a, eres, n);
      run(a, 1'b1, 0, 0, 0, res, prb, err, cyc, to);
      chk($sformatf("rnd%0d_a%0d_result", t, a), res, eres);
      chk($sformatf("rnd%0d_a%0d_probes", t, a), prb, n);
      chk($sformatf("rnd%0d_a%0d_error", t, a), err, 0);
      chk($sformatf("rnd%0d_a%0d_latency", t, a), cyc, n + 1);
      chk_seq($sformatf("rnd%0d", t), exq);
      after_done();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
